// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing controller.
package mc_pkg;

    // Controller states; all 16 codes of the 4-bit register are in use.
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_JALR_ADDR,
        S_JALR_WB,
        S_LUI,
        S_AUIPC,
        S_ILLEGAL
    } state_e;

    // RV32I major opcodes (IR[6:0]) handled by this core.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU control decoder request.
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // Register-file writeback source.
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;

    // ALU operand A source.
    localparam logic [1:0] ASRCA_PC    = 2'b00;
    localparam logic [1:0] ASRCA_OLDPC = 2'b01;
    localparam logic [1:0] ASRCA_RS1   = 2'b10;

    // ALU operand B source.
    localparam logic [1:0] ASRCB_RS2  = 2'b00;
    localparam logic [1:0] ASRCB_FOUR = 2'b01;
    localparam logic [1:0] ASRCB_IMM  = 2'b10;

    // PC load source and memory address source.
    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;
    localparam logic IORD_PC      = 1'b0;
    localparam logic IORD_ALUOUT  = 1'b1;

    // Maps a decoded opcode to the first state after DECODE.
    function automatic state_e decode_target(input logic [6:0] op);
        case (op)
            OP_R:               return S_EXEC_R;
            OP_IMM:             return S_EXEC_I;
            OP_LOAD, OP_STORE:  return S_MEM_ADDR;
            OP_BRANCH:          return S_BRANCH;
            OP_JAL:             return S_JAL;
            OP_JALR:            return S_JALR_ADDR;
            OP_LUI:             return S_LUI;
            OP_AUIPC:           return S_AUIPC;
            default:            return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Main sequencing controller for the multi-cycle RV32I core: steps each
// instruction through fetch/decode/execute/memory/writeback and stalls on
// memory wait states. Outputs are Moore decodes of the state register except
// for the mem_ready- and branch_taken-qualified enables.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       instr_retired,
    output logic       illegal
);

    state_e state_q, state_d;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: the default first keeps every path assigned, so no latch is
        // inferred for state_d.
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE:    state_d = decode_target(opcode);
            S_EXEC_R:    state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_MEM_ADDR:  state_d = opcode[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WR:    if (mem_ready) state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JAL:       state_d = S_FETCH;
            S_JALR_ADDR: state_d = S_JALR_WB;
            S_JALR_WB:   state_d = S_FETCH;
            S_LUI:       state_d = S_FETCH;
            S_AUIPC:     state_d = S_FETCH;
            S_ILLEGAL:   state_d = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // Output decode; everything is held low while rst is asserted so a
    // pending memory request drops in the reset cycle itself.
    always_comb begin
        pc_write      = 1'b0;
        pc_src        = PCSRC_ALU;
        ir_write      = 1'b0;
        iord          = IORD_PC;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_ALUOUT;
        alusrca       = ASRCA_PC;
        alusrcb       = ASRCB_RS2;
        aluop         = ALUOP_ADD;
        instr_retired = 1'b0;
        illegal       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    iord     = IORD_PC;
                    alusrca  = ASRCA_PC;
                    alusrcb  = ASRCB_FOUR;
                    aluop    = ALUOP_ADD;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PCSRC_ALU;
                    end
                end
                S_DECODE: begin
                    alusrca = ASRCA_OLDPC;
                    alusrcb = ASRCB_IMM;
                    aluop   = ALUOP_ADD;
                end
                S_EXEC_R: begin
                    alusrca = ASRCA_RS1;
                    alusrcb = ASRCB_RS2;
                    aluop   = ALUOP_FUNCT;
                end
                S_EXEC_I: begin
                    alusrca = ASRCA_RS1;
                    alusrcb = ASRCB_IMM;
                    aluop   = ALUOP_FUNCT;
                end
                S_ALU_WB, S_AUIPC: begin
                    reg_write     = 1'b1;
                    wb_sel        = WB_ALUOUT;
                    instr_retired = 1'b1;
                end
                S_MEM_ADDR, S_JALR_ADDR: begin
                    alusrca = ASRCA_RS1;
                    alusrcb = ASRCB_IMM;
                    aluop   = ALUOP_ADD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = IORD_ALUOUT;
                end
                S_MEM_WB: begin
                    reg_write     = 1'b1;
                    wb_sel        = WB_MDR;
                    instr_retired = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write     = 1'b1;
                    iord          = IORD_ALUOUT;
                    instr_retired = mem_ready;
                end
                S_BRANCH: begin
                    alusrca       = ASRCA_RS1;
                    alusrcb       = ASRCB_RS2;
                    aluop         = ALUOP_BRANCH;
                    pc_src        = PCSRC_ALUOUT;
                    pc_write      = branch_taken;
                    instr_retired = 1'b1;
                end
                // The link value (PC, already PC+4) is written in the same
                // cycle the PC loads the target; the datapath samples PC first.
                S_JAL, S_JALR_WB: begin
                    reg_write     = 1'b1;
                    wb_sel        = WB_PC;
                    pc_write      = 1'b1;
                    pc_src        = PCSRC_ALUOUT;
                    instr_retired = 1'b1;
                end
                S_LUI: begin
                    reg_write     = 1'b1;
                    wb_sel        = WB_IMM;
                    instr_retired = 1'b1;
                end
                S_ILLEGAL: begin
                    illegal = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm. Each instruction is described by
// its class plus planned wait states; the reference model predicts per-
// instruction totals (cycle count, enable pulse counts, writeback source,
// ALU requests seen) from the instruction-level rules and compares them with
// what the controller produced.
module tb_mc_control_fsm;
    import mc_pkg::*;

    localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4,
                   C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Halting instance stimulus and outputs.
    logic       rst, mem_ready, branch_taken;
    logic [6:0] opcode;
    logic       pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0] wb_sel, alusrca, alusrcb, aluop;
    logic       instr_retired, illegal;
    logic [17:0] outs;
    assign outs = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
                   wb_sel, alusrca, alusrcb, aluop, instr_retired, illegal};

    // Non-halting instance stimulus and outputs.
    logic       rst_nh, mem_ready_nh, branch_taken_nh;
    logic [6:0] opcode_nh;
    logic       nh_pc_write, nh_pc_src, nh_ir_write, nh_iord, nh_mem_read, nh_mem_write;
    logic       nh_reg_write, nh_instr_retired, nh_illegal;
    logic [1:0] nh_wb_sel, nh_alusrca, nh_alusrcb, nh_aluop;
    logic [17:0] nh_outs;
    assign nh_outs = {nh_pc_write, nh_pc_src, nh_ir_write, nh_iord, nh_mem_read, nh_mem_write,
                      nh_reg_write, nh_wb_sel, nh_alusrca, nh_alusrcb, nh_aluop,
                      nh_instr_retired, nh_illegal};

    mc_control_fsm #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .wb_sel(wb_sel), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .instr_retired(instr_retired), .illegal(illegal)
    );

    mc_control_fsm #(.HALT_ON_ILLEGAL(1'b0)) dut_nh (
        .clk(clk), .rst(rst_nh), .opcode(opcode_nh), .mem_ready(mem_ready_nh),
        .branch_taken(branch_taken_nh), .pc_write(nh_pc_write), .pc_src(nh_pc_src),
        .ir_write(nh_ir_write), .iord(nh_iord), .mem_read(nh_mem_read),
        .mem_write(nh_mem_write), .reg_write(nh_reg_write), .wb_sel(nh_wb_sel),
        .alusrca(nh_alusrca), .alusrcb(nh_alusrcb), .aluop(nh_aluop),
        .instr_retired(nh_instr_retired), .illegal(nh_illegal)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] cls_opcode(input int cls);
        case (cls)
            C_R:     return OP_R;
            C_I:     return OP_IMM;
            C_LOAD:  return OP_LOAD;
            C_STORE: return OP_STORE;
            C_BR:    return OP_BRANCH;
            C_JAL:   return OP_JAL;
            C_JALR:  return OP_JALR;
            C_LUI:   return OP_LUI;
            default: return OP_AUIPC;
        endcase
    endfunction

    // Runs one instruction starting in FETCH: fw fetch wait cycles, mw data
    // wait cycles (loads/stores), taken = branch outcome. mem_ready and
    // branch_taken carry random noise wherever the controller should ignore them.
    task automatic run_instr(input int cls, input int fw, input int mw, input bit taken,
                             input string nm);
        bit is_ld  = (cls == C_LOAD);
        bit is_st  = (cls == C_STORE);
        bit is_mem = is_ld || is_st;
        bit writes_rd = !(is_st || cls == C_BR);
        bit redirect  = (cls == C_JAL) || (cls == C_JALR) || (cls == C_BR && taken);
        int base, t_exp, mem_start;
        int cyc = 0;
        bit retired = 1'b0;
        bit first_ok = 1'b0;
        int rw_cnt = 0, pcw_cnt = 0, irw_cnt = 0, mrd_cnt = 0, mwr_cnt = 0;
        int iord_cnt = 0, ill_cnt = 0;
        logic [1:0] wb_seen = 2'b00;
        logic pcsrc_last = 1'b0;
        logic [3:0] alu_mask = 4'b0000;
        logic [3:0] alu_exp;
        logic [1:0] wb_exp;

        case (cls)
            C_R, C_I, C_JALR, C_STORE: base = 4;
            C_LOAD:                    base = 5;
            default:                   base = 3;
        endcase
        t_exp     = base + fw + (is_mem ? mw : 0);
        mem_start = fw + 3;
        case (cls)
            C_LOAD:        wb_exp = 2'b01;
            C_JAL, C_JALR: wb_exp = 2'b10;
            C_LUI:         wb_exp = 2'b11;
            default:       wb_exp = 2'b00;
        endcase
        alu_exp = 4'b0001;
        if (cls == C_R || cls == C_I) alu_exp[2] = 1'b1;
        if (cls == C_BR)              alu_exp[1] = 1'b1;

        opcode = cls_opcode(cls);
        while (!retired && cyc < t_exp + 8) begin
            if (cyc < fw)                                            mem_ready = 1'b0;
            else if (cyc == fw)                                      mem_ready = 1'b1;
            else if (is_mem && cyc >= mem_start && cyc < mem_start + mw) mem_ready = 1'b0;
            else if (is_mem && cyc == mem_start + mw)                mem_ready = 1'b1;
            else                                                     mem_ready = 1'($urandom_range(0, 1));
            branch_taken = (cyc == fw + 2) ? taken : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (cyc == 0) first_ok = mem_read && (iord == 1'b0);
            if (reg_write) begin rw_cnt++; wb_seen = wb_sel; end
            if (pc_write)  begin pcw_cnt++; pcsrc_last = pc_src; end
            if (ir_write)  irw_cnt++;
            if (mem_read)  mrd_cnt++;
            if (mem_write) mwr_cnt++;
            if (iord)      iord_cnt++;
            if (illegal)   ill_cnt++;
            alu_mask = alu_mask | (4'b0001 << aluop);
            if (instr_retired) retired = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end

        check({nm, " retired"}, 32'(retired), 32'd1);
        check({nm, " cycles"}, 32'(cyc), 32'(t_exp));
        check({nm, " first fetch"}, 32'(first_ok), 32'd1);
        check({nm, " ir_write count"}, 32'(irw_cnt), 32'd1);
        check({nm, " reg_write count"}, 32'(rw_cnt), writes_rd ? 32'd1 : 32'd0);
        if (writes_rd) check({nm, " wb_sel"}, 32'(wb_seen), 32'(wb_exp));
        check({nm, " pc_write count"}, 32'(pcw_cnt), redirect ? 32'd2 : 32'd1);
        check({nm, " last pc_src"}, 32'(pcsrc_last), 32'(redirect));
        check({nm, " mem_read cycles"}, 32'(mrd_cnt), 32'(fw + 1 + (is_ld ? mw + 1 : 0)));
        check({nm, " mem_write cycles"}, 32'(mwr_cnt), 32'(is_st ? mw + 1 : 0));
        check({nm, " iord cycles"}, 32'(iord_cnt), 32'(is_mem ? mw + 1 : 0));
        check({nm, " aluop set"}, 32'(alu_mask), 32'(alu_exp));
        check({nm, " illegal"}, 32'(ill_cnt), 32'd0);
    endtask

    task automatic pulse_reset(input string nm);
        mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check({nm, " outputs in reset"}, 32'(outs), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        automatic int ill_cnt = 0;
        automatic int mrd_cnt = 0;
        automatic int ret_cnt = 0;
        automatic logic [6:0] bad_ops [5] = '{7'h7F, 7'h00, 7'h0F, 7'h73, 7'h2F};

        rst = 1'b1; mem_ready = 1'b1; branch_taken = 1'b0; opcode = 7'h00;
        rst_nh = 1'b1; mem_ready_nh = 1'b1; branch_taken_nh = 1'b0; opcode_nh = 7'h00;

        // Two reset cycles with mem_ready high: everything must stay low.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset outputs", 32'(outs), 32'd0);
            check("reset outputs nh", 32'(nh_outs), 32'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        // Directed instructions.
        run_instr(C_R,     0, 0, 1'b0, "r-type");
        run_instr(C_LOAD,  0, 3, 1'b0, "load ws3");
        run_instr(C_BR,    0, 0, 1'b1, "branch taken");
        run_instr(C_BR,    0, 0, 1'b0, "branch not-taken");
        run_instr(C_JAL,   0, 0, 1'b0, "jal");
        run_instr(C_LUI,   0, 0, 1'b0, "lui");
        run_instr(C_I,     1, 0, 1'b0, "i-type fw1");
        run_instr(C_STORE, 0, 0, 1'b0, "store");
        run_instr(C_STORE, 2, 2, 1'b0, "store ws2");
        run_instr(C_JALR,  0, 0, 1'b0, "jalr");
        run_instr(C_AUIPC, 0, 0, 1'b0, "auipc");

        // Random instruction stream with random wait states.
        for (int n = 0; n < 150; n++) begin
            automatic int cls = int'($urandom_range(0, 8));
            automatic int fw  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            automatic int mw  = int'($urandom_range(0, 3));
            run_instr(cls, fw, mw, 1'($urandom_range(0, 1)), $sformatf("rand%0d cls%0d", n, cls));
        end

        // Reset during a fetch stall.
        opcode = OP_LOAD; mem_ready = 1'b0;
        @(negedge clk);
        check("fetch stall mem_read", 32'(mem_read), 32'd1);
        @(posedge clk);
        #1;
        pulse_reset("fetch stall");
        run_instr(C_R, 0, 0, 1'b0, "after fetch-stall reset");

        // Reset during a load data stall (MEM_RD is the 4th cycle).
        opcode = OP_LOAD;
        for (int c = 0; c < 3; c++) begin
            mem_ready = (c == 0);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        check("mem_rd stall read/iord", 32'({mem_read, iord}), 32'd3);
        @(posedge clk);
        #1;
        pulse_reset("mem_rd stall");
        run_instr(C_LOAD, 1, 1, 1'b0, "after mem_rd-stall reset");

        // Illegal opcode on the halting instance: sticky for 12 cycles.
        opcode = 7'h7F; mem_ready = 1'b1; branch_taken = 1'b0;
        for (int c = 0; c < 14; c++) begin
            mem_ready = 1'($urandom_range(0, 1)) | (c == 0);
            @(negedge clk);
            if (c >= 2) begin
                if (illegal)       ill_cnt++;
                if (mem_read)      mrd_cnt++;
                if (instr_retired) ret_cnt++;
            end
            @(posedge clk);
            #1;
        end
        check("halt illegal cycles", 32'(ill_cnt), 32'd12);
        check("halt mem_read cycles", 32'(mrd_cnt), 32'd0);
        check("halt retire count", 32'(ret_cnt), 32'd0);
        pulse_reset("mid-halt");
        run_instr(C_LUI, 0, 0, 1'b0, "after halt reset");

        // Non-halting instance: illegal pulses once, then FETCH again.
        opcode_nh = bad_ops[$urandom_range(0, 4)];
        mem_ready_nh = 1'b1;
        @(posedge clk);
        #1;
        rst_nh = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check($sformatf("nh cycle%0d ill/rd/ret", c),
                  32'({nh_illegal, nh_mem_read, nh_instr_retired}),
                  32'({(c % 3) == 2, (c % 3) == 0, 1'b0}));
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
